prog_load_ctrl: RTL
===================

# prog_load_ctrl

Sequencer that shares the instruction ROM port between the fetch unit and the UART program loader. In run mode the ROM address follows the fetch PC. On request, the block switches to load mode: it holds the CPU, packs incoming UART bytes into 32-bit words, writes them to consecutive ROM addresses, then releases the CPU. It sits between the fetch unit, the UART receiver and the program ROM.

## Interface
- ADDR_W, 14, ROM word-address width (matches PC[15:2])
- TIMEOUT_CYC, 1_000_000, idle cycles with no byte that end a load
- RELEASE_CYC, 2, cycles cpu_hold stays high after the last write
- clock  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- load_req  in  1  one-cycle pulse (debounced); enters load mode, or finishes a load already in progress
- rx_valid  in  1  one-cycle strobe; rx_byte is valid
- rx_byte  in  8  received byte
- fetch_addr  in  ADDR_W  word address from the fetch unit
- rom_addr  out  ADDR_W  ROM address port
- rom_we  out  1  ROM write enable
- rom_wdata  out  32  ROM write data
- cpu_hold  out  1  holds the fetch unit in reset
- load_busy  out  1  high in LOAD and RELEASE
- word_count  out  ADDR_W+1  words written in the current or last load
- load_done  out  1  one-cycle pulse when control returns to RUN after a load
- load_err  out  1  sticky: a partial word was discarded; cleared on the next load entry

## Operation
- States: RUN, LOAD, RELEASE. Reset state is RUN.
- Reset values: all outputs 0, rom_addr = fetch_addr, byte index 0, write pointer 0.

**RUN**
- rom_addr = fetch_addr (combinational); rom_we = 0; cpu_hold = 0.
- load_req moves the block to LOAD and, in the same transition:
  - clears the write pointer, word_count, byte index and timeout counter;
  - clears load_err.

**LOAD**
- cpu_hold = 1; rom_addr = write pointer.
- Each rx_valid stores rx_byte at lane [8*idx+7 : 8*idx] of the assembly register, then increments idx. Byte order is little-endian: the first byte goes to bits 7:0.
- When the 4th byte is accepted:
  - the full word is copied into rom_wdata;
  - a write is marked pending, so rom_we = 1 for exactly the next cycle;
  - idx wraps to 0.
  - Assembly continues during the write cycle, so no byte is lost even if bytes arrive back-to-back.
- After each write cycle: write pointer +1, word_count +1.
- Timeout counter: cleared on every rx_valid, otherwise increments.
- LOAD ends on any of:
  - timeout counter reaches TIMEOUT_CYC-1 and word_count > 0 (with 0 words the block keeps waiting);
  - load_req;
  - the write to address 2^ADDR_W-1 completes (ROM full). Later bytes are ignored.
- Exit rule: if idx != 0 at exit, the partial word is discarded and load_err is set. A write pending at exit still completes before RELEASE is entered.

**RELEASE**
- cpu_hold = 1; rom_addr = write pointer; rx_valid ignored.
- Lasts RELEASE_CYC cycles, then RUN. load_done pulses in the first RUN cycle.

**Simultaneous events**
- rx_valid and load_req in the same LOAD cycle: the byte is accepted first, then the exit rule applies. If it was the 4th byte, that word is written.
- load_req in RELEASE: ignored.

## Timing
- Byte to write: rom_we is asserted the cycle after the 4th rx_valid; rom_addr and rom_wdata are stable during that cycle.
- Last write to RUN: 1 cycle (exit decision) + RELEASE_CYC. cpu_hold falls in the same cycle load_done rises.
- RUN path rom_addr is purely combinational (zero latency), so fetch timing is unchanged.
- Reset mid-load: returns to RUN asynchronously. The ROM contents written so far remain, word_count is cleared, and no load_done is issued.

## Structure
- Shared package cpu_pkg holds:
  - the state encoding: RUN = 2'd0, LOAD = 2'd1, RELEASE = 2'd2;
  - default values for TIMEOUT_CYC and RELEASE_CYC.
- Sub-module word_packer holds the byte lane register, idx counter and word_ready strobe. The top level keeps the FSM, write pointer, timeout counter and address mux.

## Test plan
- **Basic load.** Reset, load_req, bytes 78 56 34 12 EF BE AD DE, then idle timeout.
  - ROM[0]=0x12345678, ROM[1]=0xDEADBEEF; word_count=2.
  - load_done pulses RELEASE_CYC+1 cycles after the timeout; load_err=0.
- **Back-to-back bytes.** rx_valid on 8 consecutive cycles with values 00..07.
  - Two rom_we pulses, the second at address 1 with data 0x07060504; no byte lost.
- **Partial word.** 5 bytes, then load_req.
  - One word written; load_err=1; the 5th byte is never written.
  - A new load_req clears load_err.
- **ROM full.** Use ADDR_W=2; send 20 bytes.
  - Exactly 4 writes to addresses 0..3; RELEASE is entered after the 4th write; bytes 17..20 ignored.
- **Reset mid-load.** Assert reset after 6 bytes.
  - cpu_hold=0 and rom_addr=fetch_addr immediately; word_count=0; no load_done.
- **Run-mode passthrough.** Sweep fetch_addr in RUN.
  - rom_addr mirrors it in the same cycle; rom_we stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the program-load sequencer.
//   load_state_t     : sequencer state encoding (RUN / LOAD / RELEASE)
//   TIMEOUT_CYC_DEF  : default idle cycles without a byte that end a load
//   RELEASE_CYC_DEF  : default cycles cpu_hold stays high after the last write
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RELEASE = 2'd2
   } load_state_t;

   localparam int TIMEOUT_CYC_DEF = 1_000_000;
   localparam int RELEASE_CYC_DEF = 2;

endpackage

// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Packs UART bytes little-endian into a 32-bit word.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_clear          : restart assembly at lane 0
//   i_valid, i_byte  : accepted byte strobe and value
//   o_word           : assembled word including the byte accepted this cycle
//   o_word_ready     : the 4th byte of a word is accepted this cycle
//   o_idx_next       : lane index after this cycle
// -----------------------------------------------------------------------------
module word_packer
   import cpu_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready,
   output logic [1:0]  o_idx_next
);

   logic [1:0]  r_idx;
   logic [31:0] r_asm;
   logic [3:0]  w_sel;

   // The lane being filled this cycle is taken straight from i_byte so the
   // word is complete in the same cycle its 4th byte arrives.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_sel[gi]          = i_valid && (r_idx == 2'(gi));
         assign o_word[8*gi +: 8]  = w_sel[gi] ? i_byte : r_asm[8*gi +: 8];
      end
   endgenerate

   assign o_word_ready = i_valid && (r_idx == 2'd3);
   assign o_idx_next   = i_clear ? 2'd0 : (r_idx + {1'b0, i_valid});

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_idx <= 2'd0;
         r_asm <= '0;
      end else begin
         r_idx <= o_idx_next;
         for (int k = 0; k < 4; k++) begin
            if (w_sel[k]) r_asm[8*k +: 8] <= i_byte;
         end
      end
   end

endmodule

// File: rtl/prog_load_ctrl.sv
// -----------------------------------------------------------------------------
// prog_load_ctrl
// Shares the instruction ROM port between the fetch unit and the UART loader.
//   i_clock, i_reset     : clock, asynchronous active-high reset
//   i_load_req           : enter load mode / finish a load in progress
//   i_rx_valid, i_rx_byte: received UART byte
//   i_fetch_addr         : fetch-unit word address (passed through in RUN)
//   o_rom_addr/_we/_wdata: ROM port
//   o_cpu_hold           : holds the fetch unit in reset while loading
//   o_load_busy          : high in LOAD and RELEASE
//   o_word_count         : words written by the current or last load
//   o_load_done          : one-cycle pulse on return to RUN
//   o_load_err           : sticky, a partial word was discarded
// -----------------------------------------------------------------------------
module prog_load_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int RELEASE_CYC = RELEASE_CYC_DEF
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_load_req,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_byte,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic              o_rom_we,
   output logic [31:0]       o_rom_wdata,
   output logic              o_cpu_hold,
   output logic              o_load_busy,
   output logic [ADDR_W:0]   o_word_count,
   output logic              o_load_done,
   output logic              o_load_err
);

   localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int REL_W = (RELEASE_CYC > 2) ? $clog2(RELEASE_CYC) : 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [REL_W-1:0]  REL_LAST = REL_W'(RELEASE_CYC - 1);

   load_state_t       r_state, w_state_next;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W:0]   r_wc;
   logic [TO_W-1:0]   r_tcnt;
   logic [REL_W-1:0]  r_rel;
   logic              r_pend;
   logic              r_drain;
   logic [31:0]       r_wdata;
   logic              r_err;
   logic              r_done;

   logic              w_in_load, w_enter, w_accept, w_timeout, w_full, w_exit;
   logic [31:0]       w_word;
   logic              w_word_ready;
   logic [1:0]        w_idx_next;

   assign w_in_load = (r_state == ST_LOAD);
   assign w_enter   = (r_state == ST_RUN) && i_load_req;
   // r_drain: exit already decided, only the final pending write remains.
   assign w_accept  = w_in_load && !r_drain && i_rx_valid;
   assign w_timeout = (r_tcnt == TO_LAST) && (r_wc != '0);
   // The word completing now targets r_wptr: the previous write has retired.
   assign w_full    = w_word_ready && (r_wptr == ADDR_MAX);
   assign w_exit    = w_in_load && !r_drain && (i_load_req || w_timeout || w_full);

   word_packer u_packer (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_clear      (w_enter),
      .i_valid      (w_accept),
      .i_byte       (i_rx_byte),
      .o_word       (w_word),
      .o_word_ready (w_word_ready),
      .o_idx_next   (w_idx_next)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:     if (i_load_req) w_state_next = ST_LOAD;
         // A word completing on the exit cycle is written before leaving.
         ST_LOAD:    if (r_drain || (w_exit && !w_word_ready)) w_state_next = ST_RELEASE;
         ST_RELEASE: if (r_rel == REL_LAST) w_state_next = ST_RUN;
         default:    w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_RUN;
         r_wptr  <= '0;
         r_wc    <= '0;
         r_tcnt  <= '0;
         r_rel   <= '0;
         r_pend  <= 1'b0;
         r_drain <= 1'b0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pend  <= w_word_ready;
         if (w_word_ready) r_wdata <= w_word;
         r_done  <= (r_state == ST_RELEASE) && (r_rel == REL_LAST);

         if (w_enter) begin
            r_wptr  <= '0;
            r_wc    <= '0;
            r_err   <= 1'b0;
            r_drain <= 1'b0;
         end else if (r_pend) begin
            r_wptr <= r_wptr + ADDR_W'(1);
            r_wc   <= r_wc + (ADDR_W+1)'(1);
         end

         if (w_exit) begin
            r_drain <= w_word_ready;
            if (w_idx_next != 2'd0) r_err <= 1'b1;
         end

         // Saturates so a zero-word load can wait indefinitely.
         if (w_enter || w_accept)                r_tcnt <= '0;
         else if (w_in_load && r_tcnt != TO_LAST) r_tcnt <= r_tcnt + TO_W'(1);

         if (r_state != ST_RELEASE)   r_rel <= '0;
         else if (r_rel != REL_LAST)  r_rel <= r_rel + REL_W'(1);
      end
   end

   assign o_rom_addr   = (r_state == ST_RUN) ? i_fetch_addr : r_wptr;
   assign o_rom_we     = r_pend;
   assign o_rom_wdata  = r_wdata;
   assign o_cpu_hold   = (r_state != ST_RUN);
   assign o_load_busy  = (r_state != ST_RUN);
   assign o_word_count = r_wc;
   assign o_load_done  = r_done;
   assign o_load_err   = r_err;

endmodule
